// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-clock dual-port RAM between two requesters, one access per cycle.
// Define RAM_ARB_RR_EN for round-robin arbitration in IDLE (default build: port 0 has priority).
`timescale 1ns/1ps
module ram_arbiter #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [1:0]               req,
    input  logic [1:0]               lock,
    input  logic [1:0]               we,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    output logic [1:0]               gnt,
    output logic [1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [ADDRESS_WIDTH-1:0] ram_write_address,
    output logic                     ram_write_enable,
    output logic [DATA_WIDTH-1:0]    ram_data_write,
    output logic [ADDRESS_WIDTH-1:0] ram_read_address,
    output logic                     ram_read_enable,
    input  logic [DATA_WIDTH-1:0]    ram_data_read
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t                   state, state_nxt;
    logic                     rr_last;
    logic [1:0]               arb_gnt, gnt_raw;
    logic                     win, win_we;
    logic [ADDRESS_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0]    win_wdata;
    logic [1:0]               tag_vld;
    logic [1:0]               tag_port;

    always_comb begin
        arb_gnt = 2'b00;
`ifdef RAM_ARB_RR_EN
        // on conflict the port that did not win last time goes first
        if (req == 2'b11) arb_gnt = rr_last ? 2'b01 : 2'b10;
        else              arb_gnt = req;
`else
        if (req[0])      arb_gnt = 2'b01;
        else if (req[1]) arb_gnt = 2'b10;
`endif
    end

`ifndef RAM_ARB_RR_EN
    logic unused_rr;
    assign unused_rr = rr_last;
`endif

    always_comb begin
        state_nxt = state;
        gnt_raw   = arb_gnt;
        case (state)
            IDLE: begin
                if (arb_gnt[0] && lock[0])      state_nxt = OWN0;
                else if (arb_gnt[1] && lock[1]) state_nxt = OWN1;
            end
            // owner keeps exclusive access while locked; once lock drops, normal arbitration applies
            OWN0: begin
                if (lock[0]) gnt_raw = {1'b0, req[0]};
                else         state_nxt = IDLE;
            end
            OWN1: begin
                if (lock[1]) gnt_raw = {req[1], 1'b0};
                else         state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt       = reset_n ? gnt_raw : 2'b00;
    assign win       = gnt[1];
    assign win_we    = we[win];
    assign win_addr  = win ? addr1 : addr0;
    assign win_wdata = win ? wdata1 : wdata0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            rr_last           <= 1'b1;
            ram_write_enable  <= 1'b0;
            ram_read_enable   <= 1'b0;
            ram_write_address <= '0;
            ram_read_address  <= '0;
            ram_data_write    <= '0;
            tag_vld           <= 2'b00;
            tag_port          <= 2'b00;
            rvalid            <= 2'b00;
            rdata             <= '0;
        end else begin
            state            <= state_nxt;
            ram_write_enable <= 1'b0;
            ram_read_enable  <= 1'b0;
            rvalid           <= 2'b00;
            // stage 0 mirrors the read command, stage 1 the cycle the RAM output is valid
            tag_vld          <= {tag_vld[0], (|gnt) & ~win_we};
            tag_port         <= {tag_port[0], win};
            if (|gnt) begin
                rr_last <= win;
                if (win_we) begin
                    ram_write_enable  <= 1'b1;
                    ram_write_address <= win_addr;
                    ram_data_write    <= win_wdata;
                end else begin
                    ram_read_enable  <= 1'b1;
                    ram_read_address <= win_addr;
                end
            end
            if (tag_vld[1]) begin
                rvalid <= tag_port[1] ? 2'b10 : 2'b01;
                rdata  <= ram_data_read;
            end
        end
    end
endmodule
